// File: rtl/dnn_dot_engine.sv
// Single-neuron dot-product engine: fetches bias, weight row and activations over
// Avalon-MM, accumulates Q16.16 products and writes relu?(sum + bias) back.
module dnn_dot_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        operating,
  input  logic [31:0] bias_v_addr,
  input  logic [31:0] weight_m_addr,
  input  logic [31:0] activ_addr,
  input  logic [31:0] out_activ_addr,
  input  logic [31:0] activ_len,
  input  logic [31:0] relu,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);
  typedef enum logic [3:0] {IDLE, RD_BIAS, WT_BIAS, RD_W, WT_W, RD_A, WT_A, MAC, WR} state_t;
  state_t state, state_nxt;

  logic [31:0]        bias_addr_q, w_addr_q, a_addr_q, out_addr_q, len_q;
  logic               relu_q;
  logic [31:0]        bias_q, w_q, a_q, acc, k;
  logic [31:0]        k_off, sum;
  logic signed [63:0] prod;
  logic               prod_unused;

  assign k_off       = {k[29:0], 2'b00};
  assign prod        = $signed({{32{w_q[31]}}, w_q}) * $signed({{32{a_q[31]}}, a_q});
  assign prod_unused = ^{prod[63:48], prod[15:0]};
  assign sum         = acc + bias_q;

  // Run parameters are captured once at start so the control block may reprogram freely.
  always_ff @(posedge clk) begin
    if (state == IDLE && enable) begin
      bias_addr_q <= bias_v_addr;
      w_addr_q    <= weight_m_addr;
      a_addr_q    <= activ_addr;
      out_addr_q  <= out_activ_addr;
      len_q       <= activ_len;
      relu_q      <= (relu != 32'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      k      <= '0;
      bias_q <= '0;
      w_q    <= '0;
      a_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:    if (enable) begin acc <= '0; k <= '0; end
        WT_BIAS: if (master_readdatavalid) bias_q <= master_readdata;
        WT_W:    if (master_readdatavalid) w_q <= master_readdata;
        WT_A:    if (master_readdatavalid) a_q <= master_readdata;
        MAC: begin
          acc <= acc + prod[47:16];
          k   <= k + 32'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RD_BIAS;
      RD_BIAS: if (!master_waitrequest) state_nxt = WT_BIAS;
      WT_BIAS: if (master_readdatavalid) state_nxt = (len_q == 32'd0) ? WR : RD_W;
      RD_W:    if (!master_waitrequest) state_nxt = WT_W;
      WT_W:    if (master_readdatavalid) state_nxt = RD_A;
      RD_A:    if (!master_waitrequest) state_nxt = WT_A;
      WT_A:    if (master_readdatavalid) state_nxt = MAC;
      MAC:     state_nxt = (k + 32'd1 == len_q) ? WR : RD_W;
      WR:      if (!master_waitrequest) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs depend only on state and latched registers, never on waitrequest.
  always_comb begin
    operating        = (state != IDLE);
    master_read      = 1'b0;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    case (state)
      RD_BIAS: begin master_read = 1'b1; master_address = bias_addr_q;      end
      RD_W:    begin master_read = 1'b1; master_address = w_addr_q + k_off; end
      RD_A:    begin master_read = 1'b1; master_address = a_addr_q + k_off; end
      WR: begin
        master_write     = 1'b1;
        master_address   = out_addr_q;
        master_writedata = (relu_q && sum[31]) ? 32'd0 : sum;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dnn_dot_engine.sv
// Bench for dnn_dot_engine: Avalon slave model with configurable stalls, scoreboard
// queues for read order, write result and busy duration, checked by monitor processes.
module tb_dnn_dot_engine;
  logic        clk = 1'b0;
  logic        rst_n, enable, operating;
  logic [31:0] bias_v_addr, weight_m_addr, activ_addr, out_activ_addr, activ_len, relu;
  logic        master_waitrequest, master_read, master_readdatavalid, master_write;
  logic [31:0] master_address, master_readdata, master_writedata;

  initial forever #5 clk = ~clk;

  dnn_dot_engine dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .operating(operating),
    .bias_v_addr(bias_v_addr), .weight_m_addr(weight_m_addr), .activ_addr(activ_addr),
    .out_activ_addr(out_activ_addr), .activ_len(activ_len), .relu(relu),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid), .master_write(master_write),
    .master_writedata(master_writedata)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] mem [logic [31:0]];
  wr_t         exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  int          exp_op_q[$];
  int          ws_rd = 0, ws_wr = 0, lat_x = 0;
  int          writes_seen = 0, reads_acc = 0;
  logic [31:0] wv [8];
  logic [31:0] av [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Reference: Q16.16 dot product with wrapping 32-bit accumulation, then bias and ReLU.
  function automatic logic [31:0] model(input int n, input logic [31:0] b, input logic [31:0] rl);
    logic [31:0] acc;
    logic [31:0] s;
    longint      p;
    acc = 32'd0;
    for (int i = 0; i < n; i++) begin
      p   = longint'($signed(wv[i])) * longint'($signed(av[i]));
      acc = acc + 32'(p >>> 16);
    end
    s = acc + b;
    return (rl != 32'd0 && $signed(s) < 0) ? 32'd0 : s;
  endfunction

  // Avalon slave: stalls each request, returns read data after a delay, checks the bus.
  initial begin
    logic        rd_pend;
    int          rd_cnt, stall;
    logic [31:0] rd_data, hold_addr;
    wr_t         e;
    rd_pend = 1'b0; rd_cnt = 0; stall = 0; rd_data = '0; hold_addr = '0;
    master_waitrequest = 1'b0; master_readdatavalid = 1'b0; master_readdata = '0;
    forever begin
      @(negedge clk);
      if (rd_pend && rd_cnt == 0) begin
        master_readdatavalid = 1'b1; master_readdata = rd_data; rd_pend = 1'b0;
      end else begin
        master_readdatavalid = 1'b0; master_readdata = $urandom;
        if (rd_pend) rd_cnt--;
      end
      if (rst_n && (master_read || master_write)) begin
        chk("rw_exclusive", 32'(master_read & master_write), 32'd0);
        if (stall > 0) chk("stall_addr_hold", master_address, hold_addr);
        if (stall < (master_read ? ws_rd : ws_wr)) begin
          if (stall == 0) hold_addr = master_address;
          master_waitrequest = 1'b1;
          stall++;
        end else begin
          master_waitrequest = 1'b0;
          stall = 0;
          if (master_read) begin
            chk("single_outstanding", 32'(rd_pend), 32'd0);
            if (exp_rd_q.size() == 0)
              fail("unexpected_read", $sformatf("got read at 0x%08h, required none", master_address));
            else
              chk("rd_addr", master_address, exp_rd_q.pop_front());
            rd_pend = 1'b1;
            rd_cnt  = lat_x;
            rd_data = mem.exists(master_address) ? mem[master_address] : 32'd0;
            reads_acc++;
          end else begin
            writes_seen++;
            if (exp_wr_q.size() == 0)
              fail("unexpected_write", $sformatf("got write 0x%08h at 0x%08h, required none",
                   master_writedata, master_address));
            else begin
              e = exp_wr_q.pop_front();
              chk("wr_addr", master_address, e.addr);
              chk("wr_data", master_writedata, e.data);
            end
          end
        end
      end else begin
        master_waitrequest = 1'b0;
        stall = 0;
      end
    end
  end

  // Busy-duration monitor.
  initial begin
    int   cnt;
    logic prev;
    cnt = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (operating === 1'b1) cnt++;
      else if (prev === 1'b1) begin
        if (exp_op_q.size() > 0) chk("operating_cycles", 32'(cnt), 32'(exp_op_q.pop_front()));
        cnt = 0;
      end
      prev = operating;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; enable is high for the following rising edge.
  task automatic start_run(input int n, input logic [31:0] bias, input logic [31:0] rl,
                           input logic [31:0] ba, input logic [31:0] wa, input logic [31:0] aa,
                           input logic [31:0] oa, input bit check);
    mem[ba] = bias;
    exp_rd_q.push_back(ba);
    for (int i = 0; i < n; i++) begin
      mem[wa + 32'(4*i)] = wv[i];
      mem[aa + 32'(4*i)] = av[i];
      exp_rd_q.push_back(wa + 32'(4*i));
      exp_rd_q.push_back(aa + 32'(4*i));
    end
    if (check) begin
      exp_wr_q.push_back('{oa, model(n, bias, rl)});
      exp_op_q.push_back(3 + 5*n + (1 + 2*n)*(ws_rd + lat_x) + ws_wr);
    end
    bias_v_addr = ba; weight_m_addr = wa; activ_addr = aa; out_activ_addr = oa;
    activ_len = 32'(n); relu = rl; enable = 1'b1;
    @(posedge clk); #2;
    enable = 1'b0;
    bias_v_addr = $urandom; weight_m_addr = $urandom; activ_addr = $urandom;
    out_activ_addr = $urandom; activ_len = $urandom; relu = $urandom;
    @(negedge clk);
    chk("start_operating", 32'(operating), 32'd1);
    chk("start_read", 32'(master_read), 32'd1);
    chk("start_addr", master_address, ba);
  endtask

  task automatic wait_done();
    int  tgt;
    bit  ok;
    tgt = writes_seen + 1;
    ok  = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (writes_seen >= tgt && !operating) begin ok = 1'b1; break; end
    end
    if (!ok) fail("run_timeout", "no completed write within 5000 cycles, required one");
  endtask

  initial begin
    int          n, r0, w0;
    logic [31:0] rl;
    rst_n = 1'b0; enable = 1'b0;
    bias_v_addr = $urandom; weight_m_addr = $urandom; activ_addr = $urandom;
    out_activ_addr = $urandom; activ_len = $urandom; relu = $urandom;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("reset_operating", 32'(operating), 32'd0);
    chk("reset_read", 32'(master_read), 32'd0);
    chk("reset_write", 32'(master_write), 32'd0);
    chk("reset_address", master_address, 32'd0);
    chk("reset_writedata", master_writedata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // N=0: bias only.
    start_run(0, 32'h0001_0000, 32'd0, 32'h100, 32'h200, 32'h300, 32'h400, 1'b1);
    wait_done();

    // N=2 positive, then negative sum without and with ReLU (back-to-back starts).
    wv[0] = 32'h0002_0000; wv[1] = 32'h0000_8000;
    av[0] = 32'h0003_0000; av[1] = 32'h0004_0000;
    start_run(2, 32'h0001_0000, 32'd0, 32'h100, 32'h200, 32'h300, 32'h400, 1'b1);
    wait_done();
    start_run(2, 32'hFFF0_0000, 32'd0, 32'h100, 32'h200, 32'h300, 32'h404, 1'b1);
    wait_done();
    start_run(2, 32'hFFF0_0000, 32'd1, 32'h100, 32'h200, 32'h300, 32'h408, 1'b1);
    wait_done();

    // Stalled bus.
    ws_rd = 3; lat_x = 1; ws_wr = 0;
    start_run(2, 32'h0001_0000, 32'd0, 32'h100, 32'h200, 32'h300, 32'h40C, 1'b1);
    wait_done();
    ws_rd = 0; lat_x = 0;
    repeat (2) @(negedge clk);

    // Enable pulsed while busy is ignored.
    start_run(2, 32'h0001_0000, 32'd0, 32'h100, 32'h200, 32'h300, 32'h410, 1'b1);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("no_restart_after_busy_enable", 32'(operating), 32'd0);

    // Reset while waiting for the weight read data; the late data must be dropped.
    lat_x = 3;
    r0 = reads_acc; w0 = writes_seen;
    start_run(2, 32'h0001_0000, 32'd0, 32'h100, 32'h200, 32'h300, 32'h414, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
        if (reads_acc >= r0 + 2) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      if (!seen) fail("reset_setup_timeout", "weight read not accepted, required acceptance");
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrun_reset_operating", 32'(operating), 32'd0);
    chk("midrun_reset_read", 32'(master_read), 32'd0);
    chk("midrun_reset_write", 32'(master_write), 32'd0);
    repeat (8) @(negedge clk);
    chk("no_write_after_reset", 32'(writes_seen), 32'(w0));
    chk("idle_after_reset", 32'(operating), 32'd0);
    exp_rd_q.delete();
    lat_x = 0;
    start_run(2, 32'h0001_0000, 32'd0, 32'h100, 32'h200, 32'h300, 32'h418, 1'b1);
    wait_done();

    // Randomized runs with random stall profiles.
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        wv[i] = $urandom;
        av[i] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000;
      end
      ws_rd = $urandom_range(0, 2); lat_x = $urandom_range(0, 2); ws_wr = $urandom_range(0, 2);
      rl = ($urandom_range(0, 1) != 0) ? ($urandom | 32'h8000_0000) : 32'd0;
      start_run(n, $urandom, rl,
                32'h1000_0000 | ($urandom & 32'h00FF_FFFC),
                32'h2000_0000 | ($urandom & 32'h00FF_FFFC),
                32'h3000_0000 | ($urandom & 32'h00FF_FFFC),
                32'h4000_0000 | ($urandom & 32'h00FF_FFFC), 1'b1);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("pending_writes", 32'(exp_wr_q.size()), 32'd0);
    chk("pending_reads", 32'(exp_rd_q.size()), 32'd0);
    chk("pending_op_checks", 32'(exp_op_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
